// File: rtl/softex_stream_lane_filler_if.sv
// Byte-strobed valid/ready stream bundle shared by the lane filler and its neighbours.
// master drives valid/data/strb and samples ready; slave is the mirror image.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/softex_stream_lane_filler.sv
// Replaces strobed-off bytes with a fill pattern behind a 2-entry skid buffer and flags vector end.
// Optional SOFTEX_LANE_FILL_STATS_EN adds filled_beats_o, a saturating count of partial input beats.
module softex_stream_lane_filler #(
    parameter int unsigned DW     = 256,
    parameter int unsigned FILL_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [FILL_W-1:0]     fill_i,
    input  logic [31:0]           tot_len_i,
    hwpe_stream_intf_stream.slave  stream_i,
    hwpe_stream_intf_stream.master stream_o,
    output logic                  done_o
`ifdef SOFTEX_LANE_FILL_STATS_EN
    ,
    output logic [31:0]           filled_beats_o
`endif
);

    localparam int NB = int'(DW / 8);
    localparam int FB = int'(FILL_W / 8);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   head_q, head_d;
    logic [DW-1:0]   tail_q, tail_d;
    logic [DW-1:0]   filled;
    logic            ready_q;
    logic            out_valid;
    logic            in_hs;
    logic            out_hs;
    logic [31:0]     cnt_q, cnt_d;
    logic            done_q, done_d;

    // Lane i takes the fill byte at the same offset within the repeating fill element.
    always_comb begin
        filled = stream_i.data;
        for (int i = 0; i < NB; i++) begin
            if (!stream_i.strb[i]) begin
                filled[8*i +: 8] = fill_i[8*(i % FB) +: 8];
            end
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_hs     = stream_i.valid & ready_q;
    assign out_hs    = out_valid & stream_o.ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (state_d != FULL);
        end
    end

    // head is always the oldest beat; tail only holds the skid beat while FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clear_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        head_d  = filled;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        head_d = filled;
                    end else if (in_hs) begin
                        tail_d  = filled;
                        state_d = FULL;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // A zero length leaves the counter frozen; the length is re-read on every beat.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (out_hs && (tot_len_i != 32'd0)) begin
            if (cnt_q == tot_len_i - 32'd1) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

`ifdef SOFTEX_LANE_FILL_STATS_EN
    logic [31:0] stats_q, stats_d;

    always_comb begin
        stats_d = stats_q;
        if (clear_i) begin
            stats_d = '0;
        end else if (in_hs && !(&stream_i.strb) && (stats_q != 32'hFFFF_FFFF)) begin
            stats_d = stats_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign filled_beats_o = stats_q;
`endif

    assign stream_i.ready = ready_q;
    assign stream_o.valid = out_valid;
    assign stream_o.data  = head_q;
    assign stream_o.strb  = out_valid ? {NB{1'b1}} : {NB{1'b0}};
    assign done_o         = done_q;

endmodule

// File: tb/tb_softex_stream_lane_filler.sv
// Directed bench for the lane filler: a queue model of the held beats and the vector
// counter is compared every cycle, with literal expectations pinning key scenarios.
module tb_softex_stream_lane_filler;

    localparam int DW = 256;
    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic [15:0]   fill = 16'hFF80;
    logic [31:0]   tot_len = 32'd0;
    logic          done;
`ifdef SOFTEX_LANE_FILL_STATS_EN
    logic [31:0]   filled_beats;
`endif

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if ();

    softex_stream_lane_filler #(.DW(DW), .FILL_W(16)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (clear),
        .fill_i    (fill),
        .tot_len_i (tot_len),
        .stream_i  (in_if),
        .stream_o  (out_if),
        .done_o    (done)
`ifdef SOFTEX_LANE_FILL_STATS_EN
        ,
        .filled_beats_o (filled_beats)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] apply_fill(logic [DW-1:0] d, logic [NB-1:0] s, logic [15:0] f);
        for (int i = 0; i < NB; i++)
            if (!s[i]) d[8*i +: 8] = (i % 2 == 0) ? f[7:0] : f[15:8];
        return d;
    endfunction

    function automatic logic [DW-1:0] beat_data(int b);
        logic [DW-1:0] d;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'((b * 32 + i) % 256);
        return d;
    endfunction

    // Model: the buffer is just an ordered list of at most two filled beats.
    logic [DW-1:0] q[$];
    int unsigned   cnt_m = 0;
    bit            done_m = 0;
    bit            checking = 0;
    bit            in_hs_m, out_hs_m;
    int            out_dut = 0;
    int            dut_dones = 0;
    logic [DW-1:0] last_out = '0;
    longint        filled_m = 0;

    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", out_if.valid, q.size() != 0);
            check("out_strb", out_if.strb, (q.size() != 0) ? {NB{1'b1}} : {NB{1'b0}});
            if (q.size() != 0) check("out_data", out_if.data, q[0]);
            check("in_ready", in_if.ready, q.size() < 2);
            check("done", done, done_m);
`ifdef SOFTEX_LANE_FILL_STATS_EN
            check("filled_beats", filled_beats, filled_m[31:0]);
`endif
            if (out_if.valid && out_if.ready) begin
                out_dut++;
                last_out = out_if.data;
            end
            if (done) dut_dones++;

            in_hs_m  = in_if.valid && (q.size() < 2);
            out_hs_m = (q.size() != 0) && out_if.ready;
            if (clear) begin
                q.delete();
                cnt_m    = 0;
                done_m   = 0;
                filled_m = 0;
            end else begin
                done_m = 0;
                if (out_hs_m) begin
                    void'(q.pop_front());
                    if (tot_len != 0) begin
                        if (cnt_m + 1 == tot_len) begin
                            cnt_m  = 0;
                            done_m = 1;
                        end else begin
                            cnt_m++;
                        end
                    end
                end
                if (in_hs_m) begin
                    q.push_back(apply_fill(in_if.data, in_if.strb, fill));
                    if (in_if.strb != {NB{1'b1}} && filled_m < 64'hFFFF_FFFF) filled_m++;
                end
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(logic [DW-1:0] d, logic [NB-1:0] s);
        bit hs;
        int t;
        hs = 0;
        t  = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.strb  = s;
        do begin
            @(negedge clk);
            hs = in_if.ready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        if (!hs) begin
            checks++;
            $display("[TB] FAIL send_timeout: got ready=0 for %0d cycles expected handshake", t);
        end
        in_if.valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    logic [DW-1:0] rnd;
    int            t0, d0;
    bit            sdone, rdone;

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.strb   = '0;
        out_if.ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", out_if.valid, 0);
        check("rst_data", out_if.data, '0);
        check("rst_strb", out_if.strb, '0);
        check("rst_ready", in_if.ready, 1);
        check("rst_done", done, 0);
        cycles(2);
        rst_n    = 1'b1;
        checking = 1;

        // Full-strobe beats pass unchanged at one beat per cycle, one cycle latency.
        cycles(1);
        t0 = cyc;
        send_beat(beat_data(0), {NB{1'b1}});
        check("lat_valid", out_if.valid, 1);
        check("lat_data", out_if.data, beat_data(0));
        for (int b = 1; b < 8; b++) send_beat(beat_data(b), {NB{1'b1}});
        check("thru_cycles", cyc - t0, 8);
        cycles(1);
        check("thru_beats", out_dut, 8);

        // Three-beat vector with a partial last beat.
        tot_len = 32'd3;
        d0 = dut_dones;
        send_beat(beat_data(10), {NB{1'b1}});
        send_beat(beat_data(11), {NB{1'b1}});
        for (int i = 0; i < NB; i++) rnd[8*i +: 8] = 8'(8'hA0 + i);
        send_beat(rnd, 32'h0000_003F);
        cycles(3);
        check("partial_data", last_out, {{13{16'hFF80}}, 48'hA5A4A3A2A1A0});
        check("vec3_dones", dut_dones - d0, 1);

        // Output stall under continuous input fills the skid buffer.
        tot_len = 32'd0;
        out_if.ready = 1'b0;
        sdone = 0;
        fork
            begin
                for (int b = 20; b < 26; b++)
                    send_beat(beat_data(b), (b == 22) ? {NB{1'b0}} : {NB{1'b1}});
                sdone = 1;
            end
        join_none
        cycles(4);
        check("stall_ready", in_if.ready, 0);
        check("stall_valid", out_if.valid, 1);
        out_if.ready = 1'b1;
        for (int t = 0; t < 100 && !sdone; t++) cycles(1);
        cycles(3);
        check("stall_drained", out_if.valid, 0);

        // Random traffic over 1000 beats of 7-beat vectors.
        pulse_clear();
        tot_len = 32'd7;
        d0 = dut_dones;
        rdone = 0;
        fork
            begin
                for (int b = 0; b < 1000; b++) begin
                    if ($urandom_range(0, 1) == 1) cycles(1);
                    for (int w = 0; w < 8; w++) rnd[32*w +: 32] = $urandom;
                    send_beat(rnd, $urandom);
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    out_if.ready = ($urandom_range(0, 1) == 1);
                    cycles(1);
                end
            end
        join
        out_if.ready = 1'b1;
        cycles(5);
        check("rand_dones", dut_dones - d0, 142);

        // Clear while FULL and stalled drops the held beats and restarts the count.
        pulse_clear();
        tot_len = 32'd4;
        send_beat(beat_data(40), {NB{1'b1}});
        send_beat(beat_data(41), {NB{1'b1}});
        cycles(1);
        out_if.ready = 1'b0;
        send_beat(beat_data(42), {NB{1'b1}});
        send_beat(beat_data(43), {NB{1'b1}});
        check("pre_clear_ready", in_if.ready, 0);
        pulse_clear();
        check("clear_valid", out_if.valid, 0);
        check("clear_ready", in_if.ready, 1);
        out_if.ready = 1'b1;
        d0 = dut_dones;
        for (int b = 0; b < 4; b++) send_beat(beat_data(50 + b), {NB{1'b1}});
        cycles(2);
        check("post_clear_dones", dut_dones - d0, 1);

`ifdef SOFTEX_LANE_FILL_STATS_EN
        pulse_clear();
        send_beat(beat_data(60), {NB{1'b1}});
        send_beat(beat_data(61), 32'h0000_FFFF);
        send_beat(beat_data(62), {NB{1'b1}});
        send_beat(beat_data(63), 32'h0000_0000);
        send_beat(beat_data(64), {NB{1'b1}});
        cycles(2);
        check("stats_count", filled_beats, 32'd2);
        pulse_clear();
        check("stats_clear", filled_beats, 32'd0);
`endif

        // Asynchronous reset while beats are held.
        tot_len = 32'd0;
        out_if.ready = 1'b0;
        send_beat(beat_data(70), {NB{1'b1}});
        send_beat(beat_data(71), {NB{1'b1}});
        #2;
        checking = 0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_if.valid, 0);
        check("arst_ready", in_if.ready, 1);
        check("arst_data", out_if.data, '0);
        check("arst_done", done, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
